// File: rtl/ifetch_unit.sv
// ifetch_unit: owns the fetch PC, issues imem reads over req/gnt/rvalid and hands instructions to decode over valid/ready
//   Ports: clk, rst (async, active-high)
//          imem_req/imem_addr out, imem_gnt/imem_rvalid/imem_rdata in   -- instruction memory, one outstanding read
//          if_valid/if_pc/if_instr out, if_ready in                     -- decode handoff
//          redirect/redirect_pc in                                      -- next-PC override, squashes in-flight fetch
//          fetch_pc out                                                 -- current fetch PC (trace)
//          if_misalign out (only with IFETCH_MISALIGN_CHK_EN)           -- flags a misaligned redirect target
module ifetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] fetch_pc
`ifdef IFETCH_MISALIGN_CHK_EN
   ,
   output logic        if_misalign
`endif
);
   localparam logic [1:0] REQ  = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;
   logic [1:0]  state;
   logic [31:0] pc, req_pc, rpc_al;
   logic        discard, mis;
   assign rpc_al    = redirect_pc & 32'hFFFF_FFFC;
   assign imem_req  = (state == REQ) & ~rst;
   assign imem_addr = {pc[31:2], 2'b00};
   assign fetch_pc  = pc;
`ifdef IFETCH_MISALIGN_CHK_EN
   assign mis = redirect & |redirect_pc[1:0];
`else
   assign mis = 1'b0;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc       <= RESET_PC;
         req_pc   <= RESET_PC;
         state    <= REQ;
         discard  <= 1'b0;
         if_valid <= 1'b0;
         if_pc    <= 32'h0;
         if_instr <= NOP_INSTR;
`ifdef IFETCH_MISALIGN_CHK_EN
         if_misalign <= 1'b0;
`endif
      end else if (mis) begin
         // misaligned target: no fetch, present a flagged NOP entry instead
         pc       <= rpc_al;
         state    <= HOLD;
         discard  <= 1'b0;
         if_valid <= 1'b1;
         if_pc    <= redirect_pc;
         if_instr <= NOP_INSTR;
`ifdef IFETCH_MISALIGN_CHK_EN
         if_misalign <= 1'b1;
`endif
      end else if (redirect) begin
         pc <= rpc_al;
`ifdef IFETCH_MISALIGN_CHK_EN
         if_misalign <= 1'b0;
`endif
         if (state == REQ && imem_gnt) begin
            // granted request now targets the old path; its response must be dropped
            state   <= WAIT;
            discard <= 1'b1;
         end else if (state == WAIT) begin
            state   <= imem_rvalid ? REQ : WAIT;
            discard <= ~imem_rvalid;
         end else if (state == HOLD) begin
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
            state    <= REQ;
         end
      end else if (state == REQ && imem_gnt) begin
         pc     <= pc + 32'd4;
         req_pc <= imem_addr;
         state  <= WAIT;
      end else if (state == WAIT && imem_rvalid) begin
         discard <= 1'b0;
         state   <= discard ? REQ : HOLD;
         if (!discard) begin
            if_valid <= 1'b1;
            if_pc    <= req_pc;
            if_instr <= imem_rdata;
         end
      end else if (state == HOLD && if_ready) begin
         if_valid <= 1'b0;
         if_instr <= NOP_INSTR;
         state    <= REQ;
`ifdef IFETCH_MISALIGN_CHK_EN
         if_misalign <= 1'b0;
`endif
      end
   end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: cycle-by-cycle directed vectors for ifetch_unit plus reset-wrap and mid-fetch reset sequences
module tb_ifetch_unit;
   localparam logic [31:0] N = 32'h0000_0013;
   logic clk = 1'b0, rst = 1'b1;
   logic gnt = 0, rv = 0, rdy = 0, rdir = 0;
   logic [31:0] rdata = 0, rpc = 0;
   logic req, valid;
   logic [31:0] addr, pc, instr, fpc;
   logic w_req, w_valid;
   logic [31:0] w_addr, w_pc, w_instr, w_fpc;
`ifdef IFETCH_MISALIGN_CHK_EN
   logic mis, w_mis;
`endif
   int n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   ifetch_unit dut (
      .clk(clk), .rst(rst), .imem_req(req), .imem_addr(addr), .imem_gnt(gnt),
      .imem_rvalid(rv), .imem_rdata(rdata), .if_valid(valid), .if_ready(rdy),
      .if_pc(pc), .if_instr(instr), .redirect(rdir), .redirect_pc(rpc), .fetch_pc(fpc)
`ifdef IFETCH_MISALIGN_CHK_EN
      , .if_misalign(mis)
`endif
   );

   ifetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(1'b1),
      .imem_rvalid(1'b1), .imem_rdata(32'h1234_5678), .if_valid(w_valid), .if_ready(1'b1),
      .if_pc(w_pc), .if_instr(w_instr), .redirect(1'b0), .redirect_pc(32'h0), .fetch_pc(w_fpc)
`ifdef IFETCH_MISALIGN_CHK_EN
      , .if_misalign(w_mis)
`endif
   );

   typedef struct {
      logic g, v, r, d;
      logic [31:0] rd, rp;
      logic ereq, eval;
      logic [31:0] eaddr, epc, einstr;
   } vec_t;
   vec_t tbl[$];

   task automatic row(input logic g, v, input logic [31:0] rd, input logic r, d, input logic [31:0] rp,
                      input logic ereq, input logic [31:0] eaddr, input logic eval, input logic [31:0] epc, einstr);
      vec_t t;
      t.g = g; t.v = v; t.rd = rd; t.r = r; t.d = d; t.rp = rp;
      t.ereq = ereq; t.eaddr = eaddr; t.eval = eval; t.epc = epc; t.einstr = einstr;
      tbl.push_back(t);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input logic ereq, input logic [31:0] eaddr, input logic eval,
                          input logic [31:0] epc, einstr);
      chk({nm, ".req"}, {31'b0, req}, {31'b0, ereq});
      chk({nm, ".addr"}, addr, eaddr);
      chk({nm, ".fetch_pc"}, fpc, eaddr);
      chk({nm, ".valid"}, {31'b0, valid}, {31'b0, eval});
      chk({nm, ".if_pc"}, pc, epc);
      chk({nm, ".instr"}, instr, einstr);
   endtask

   initial begin
      //   g  v  rdata            r  d  rpc            req addr          val pc            instr
      row(1, 0, 0,               0, 0, 0,            1, 32'h000,       0, 32'h000,      N);
      row(0, 1, 32'hA000_0000,   0, 0, 0,            0, 32'h004,       0, 32'h000,      N);
      row(0, 0, 0,               1, 0, 0,            0, 32'h004,       1, 32'h000,      32'hA000_0000);
      row(1, 0, 0,               0, 0, 0,            1, 32'h004,       0, 32'h000,      N);
      row(0, 1, 32'hA000_0004,   0, 0, 0,            0, 32'h008,       0, 32'h000,      N);
      for (int k = 0; k < 5; k++)
         row(0, 0, 0,            0, 0, 0,            0, 32'h008,       1, 32'h004,      32'hA000_0004);
      row(0, 0, 0,               1, 0, 0,            0, 32'h008,       1, 32'h004,      32'hA000_0004);
      row(1, 0, 0,               0, 0, 0,            1, 32'h008,       0, 32'h004,      N);
      row(0, 0, 0,               0, 1, 32'h100,      0, 32'h00C,       0, 32'h004,      N);
      row(0, 0, 0,               0, 0, 0,            0, 32'h100,       0, 32'h004,      N);
      row(0, 1, 32'hA000_0008,   0, 0, 0,            0, 32'h100,       0, 32'h004,      N);
      row(1, 0, 0,               0, 0, 0,            1, 32'h100,       0, 32'h004,      N);
      row(0, 1, 32'hA000_0100,   0, 0, 0,            0, 32'h104,       0, 32'h004,      N);
      row(0, 0, 0,               1, 0, 0,            0, 32'h104,       1, 32'h100,      32'hA000_0100);
      row(0, 0, 0,               0, 0, 0,            1, 32'h104,       0, 32'h100,      N);
      row(1, 0, 0,               0, 0, 0,            1, 32'h104,       0, 32'h100,      N);
      row(0, 1, 32'hA000_0104,   0, 0, 0,            0, 32'h108,       0, 32'h100,      N);
      row(0, 0, 0,               1, 0, 0,            0, 32'h108,       1, 32'h104,      32'hA000_0104);
      row(1, 0, 0,               0, 1, 32'h200,      1, 32'h108,       0, 32'h104,      N);
      row(0, 1, 32'hA000_0108,   0, 0, 0,            0, 32'h200,       0, 32'h104,      N);
      row(1, 0, 0,               0, 0, 0,            1, 32'h200,       0, 32'h104,      N);
      row(0, 1, 32'hA000_0200,   0, 0, 0,            0, 32'h204,       0, 32'h104,      N);
      row(0, 0, 0,               1, 1, 32'h300,      0, 32'h204,       1, 32'h200,      32'hA000_0200);
      row(0, 0, 0,               0, 1, 32'h404,      1, 32'h300,       0, 32'h200,      N);
      row(1, 0, 0,               0, 0, 0,            1, 32'h404,       0, 32'h200,      N);
      row(0, 1, 32'hA000_0404,   0, 0, 0,            0, 32'h408,       0, 32'h200,      N);
      row(0, 0, 0,               1, 0, 0,            0, 32'h408,       1, 32'h404,      32'hA000_0404);
      row(1, 1, 32'hBAD0_BAD0,   0, 0, 0,            1, 32'h408,       0, 32'h404,      N);
      row(0, 0, 0,               0, 0, 0,            0, 32'h40C,       0, 32'h404,      N);
      row(0, 1, 32'hA000_0408,   0, 0, 0,            0, 32'h40C,       0, 32'h404,      N);
      row(0, 0, 0,               1, 0, 0,            0, 32'h40C,       1, 32'h408,      32'hA000_0408);
      row(1, 0, 0,               0, 0, 0,            1, 32'h40C,       0, 32'h408,      N);

      @(negedge clk);
      #1 chk_out("reset", 0, 32'h0, 0, 32'h0, N);
      chk("reset.wrap_req", {31'b0, w_req}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < tbl.size(); i++) begin
         gnt = tbl[i].g; rv = tbl[i].v; rdata = tbl[i].rd; rdy = tbl[i].r; rdir = tbl[i].d; rpc = tbl[i].rp;
         #1 chk_out($sformatf("vec%0d", i), tbl[i].ereq, tbl[i].eaddr, tbl[i].eval, tbl[i].epc, tbl[i].einstr);
         if (i == 0) chk("wrap.addr0", w_req ? w_addr : 32'hDEAD, 32'hFFFF_FFFC);
         if (i == 2) chk("wrap.pc0", w_valid ? w_pc : 32'hDEAD, 32'hFFFF_FFFC);
         if (i == 3) chk("wrap.addr1", w_req ? w_addr : 32'hDEAD, 32'h0000_0000);
         @(negedge clk);
      end
      // reset while a read is outstanding; the late response must be ignored
      gnt = 0; rdy = 0; rdir = 0; rst = 1'b1; rv = 1'b1; rdata = 32'hBAD1_BAD1;
      #1 chk_out("rst_mid", 0, 32'h0, 0, 32'h0, N);
      @(negedge clk);
      rst = 1'b0; gnt = 1'b1; rv = 1'b1;
      #1 chk_out("post_rst_req", 1, 32'h0, 0, 32'h0, N);
      @(negedge clk);
      gnt = 0; rv = 1'b1; rdata = 32'hDEAD_0001;
      #1 chk_out("post_rst_wait", 0, 32'h4, 0, 32'h0, N);
      @(negedge clk);
      rv = 0;
      #1 chk_out("post_rst_hold", 0, 32'h4, 1, 32'h0, 32'hDEAD_0001);
`ifdef IFETCH_MISALIGN_CHK_EN
      chk("mis.reset", {31'b0, mis}, 32'h0);
      rdir = 1'b1; rpc = 32'h102;
      @(negedge clk);
      rdir = 1'b0;
      #1 chk_out("mis_hold", 0, 32'h100, 1, 32'h102, N);
      chk("mis.flag", {31'b0, mis}, 32'h1);
      rdy = 1'b1;
      @(negedge clk);
      rdy = 1'b0;
      #1 chk_out("mis_consumed", 1, 32'h100, 0, 32'h102, N);
      chk("mis.clear", {31'b0, mis}, 32'h0);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
